// File: rtl/medidor_pkg.sv
// Shared constants and state encoding for the period meter.
// Ports: none (package only).
package medidor_pkg;

    // Default width of the recovered setting and of the cycle counter.
    localparam int WIDTH_DEF = 6;

    // Width of the consecutive-match counter (covers LOCK_COUNT 2..15).
    localparam int LOCK_W = 4;

    typedef enum logic {
        ESPERA = 1'b0,
        MIDE   = 1'b1
    } estado_t;

endpackage

// File: rtl/detector_de_flancos.sv
// Toggle detector for the divided clock; optional 2-flop synchronizer
// selected by MEDIDOR_SYNC_EN.
// Ports: clk_i, rst_i (sync, active-high), d_i (wave), flanco_o (toggle seen).
module detector_de_flancos
    import medidor_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic flanco_o
);

    logic d_s;
    logic d_prev_q;

`ifdef MEDIDOR_SYNC_EN
    logic s1_q;
    logic s2_q;

    // Reset loads the live input so no false toggle appears at release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= d_i;
            s2_q <= d_i;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign d_s = s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) d_prev_q <= d_i;
        else       d_prev_q <= d_s;
    end
`else
    assign d_s = d_i;

    always_ff @(posedge clk_i) begin
        d_prev_q <= d_s;
    end
`endif

    assign flanco_o = d_s ^ d_prev_q;

endmodule

// File: rtl/medidor_de_periodo.sv
// Recovers a divider setting from the half-period of a square wave.
// Ports: CLK, Reset (sync, active-high), D (wave in), Q (setting),
// Valido (capture strobe), Bloqueado (lock), Desborde (sticky overflow).
// Optional macro: MEDIDOR_SYNC_EN adds a 2-flop input synchronizer.
module medidor_de_periodo
    import medidor_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int LOCK_COUNT = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             D,
    output logic [WIDTH-1:0] Q,
    output logic             Valido,
    output logic             Bloqueado,
    output logic             Desborde
);

    localparam logic [WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [LOCK_W-1:0] LOCK_V  = LOCK_W'(LOCK_COUNT);

    logic flanco;

    estado_t           state_q, state_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              valido_q, valido_d;
    logic              bloq_q, bloq_d;
    logic              desb_q, desb_d;
    logic [LOCK_W-1:0] match_q, match_d;

    detector_de_flancos u_det (
        .clk_i    (CLK),
        .rst_i    (Reset),
        .d_i      (D),
        .flanco_o (flanco)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= ESPERA;
            cnt_q    <= '0;
            q_q      <= '0;
            valido_q <= 1'b0;
            bloq_q   <= 1'b0;
            desb_q   <= 1'b0;
            match_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            valido_q <= valido_d;
            bloq_q   <= bloq_d;
            desb_q   <= desb_d;
            match_q  <= match_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        valido_d = 1'b0;
        bloq_d   = bloq_q;
        desb_d   = desb_q;
        match_d  = match_q;
        unique case (state_q)
            ESPERA: begin
                // First toggle only establishes the phase reference.
                if (flanco) begin
                    cnt_d   = '0;
                    state_d = MIDE;
                end
            end
            MIDE: begin
                // A toggle wins even when the counter sits at its maximum.
                if (flanco) begin
                    q_d      = cnt_q;
                    valido_d = 1'b1;
                    cnt_d    = '0;
                    desb_d   = 1'b0;
                    if (cnt_q == q_q) begin
                        if (match_q != LOCK_V) match_d = match_q + 1'b1;
                    end else begin
                        match_d = LOCK_W'(1);
                    end
                    bloq_d = (match_d == LOCK_V);
                end else if (cnt_q == CNT_MAX) begin
                    desb_d  = 1'b1;
                    bloq_d  = 1'b0;
                    match_d = '0;
                    state_d = ESPERA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ESPERA;
        endcase
    end

    assign Q         = q_q;
    assign Valido    = valido_q;
    assign Bloqueado = bloq_q;
    assign Desborde  = desb_q;

endmodule

// File: tb/tb_medidor_de_periodo.sv
// Directed self-checking bench for medidor_de_periodo.
// Works with or without MEDIDOR_SYNC_EN (edge latency LAT).
module tb_medidor_de_periodo;

`ifdef MEDIDOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       Reset;
    logic       D;
    logic [5:0] Q;
    logic       Valido;
    logic       Bloqueado;
    logic       Desborde;

    int ncmp = 0;
    int nfail = 0;

    medidor_de_periodo dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .D         (D),
        .Q         (Q),
        .Valido    (Valido),
        .Bloqueado (Bloqueado),
        .Desborde  (Desborde)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Toggle D, then run one half-period of n+1 cycles, recording strobes.
    task automatic half(input int n, output int vc, output int vp,
                        output int vq, output int vb);
        vc = 0; vp = 0; vq = -1; vb = -1;
        D = ~D;
        for (int i = 1; i <= n + 1; i++) begin
            step();
            if (Valido === 1'b1) begin
                vc++;
                vp = i;
                vq = int'(Q);
                vb = int'(Bloqueado);
            end
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic hold(input int n, output int vc, output int dc);
        vc = 0; dc = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (Valido === 1'b1) vc++;
            if (Desborde === 1'b1) dc++;
        end
    endtask

    initial begin
        int vc, vp, vq, vb, dc;
        Reset = 1'b1;
        D = 1'b0;
        step();
        step();
        check("rst_Q", int'(Q), 0);
        check("rst_V", int'(Valido), 0);
        check("rst_B", int'(Bloqueado), 0);
        check("rst_D", int'(Desborde), 0);
        Reset = 1'b0;
        hold(3, vc, dc);
        check("idle_v", vc, 0);

        // N=5
        half(5, vc, vp, vq, vb);
        check("n5_ref_vc", vc, 0);
        half(5, vc, vp, vq, vb);
        check("n5_a_vc", vc, 1);
        check("n5_a_pos", vp, 1 + LAT);
        check("n5_a_q", vq, 5);
        check("n5_a_b", vb, 0);
        half(5, vc, vp, vq, vb);
        check("n5_b_vc", vc, 1);
        check("n5_b_pos", vp, 1 + LAT);
        check("n5_b_q", vq, 5);
        check("n5_b_b", vb, 1);
        check("n5_desb", int'(Desborde), 0);

        // Change 5 -> 9
        half(9, vc, vp, vq, vb);
        check("ch_old_q", vq, 5);
        check("ch_old_b", vb, 1);
        half(9, vc, vp, vq, vb);
        check("ch_a_q", vq, 9);
        check("ch_a_b", vb, 0);
        half(9, vc, vp, vq, vb);
        check("ch_b_q", vq, 9);
        check("ch_b_b", vb, 1);

        // N=0
        do_reset();
        for (int i = 0; i < 10; i++) half(0, vc, vp, vq, vb);
        vc = 0;
        for (int i = 0; i < 4; i++) begin
            D = ~D;
            step();
            if (Valido === 1'b1) vc++;
        end
        check("n0_vc", vc, 4);
        check("n0_q", int'(Q), 0);
        check("n0_b", int'(Bloqueado), 1);

        // N=63 then overflow
        do_reset();
        half(63, vc, vp, vq, vb);
        check("n63_ref_vc", vc, 0);
        half(63, vc, vp, vq, vb);
        check("n63_a_q", vq, 63);
        check("n63_a_desb", int'(Desborde), 0);
        half(63, vc, vp, vq, vb);
        check("n63_b_q", vq, 63);
        check("n63_b_b", vb, 1);
        hold(LAT, vc, dc);
        check("ovf_pre", int'(Desborde), 0);
        step();
        check("ovf_desb", int'(Desborde), 1);
        check("ovf_b", int'(Bloqueado), 0);
        check("ovf_q", int'(Q), 63);
        hold(10, vc, dc);
        check("ovf_sticky", dc, 10);
        check("ovf_nov", vc, 0);
        half(5, vc, vp, vq, vb);
        check("ovf_ref_vc", vc, 0);
        check("ovf_ref_desb", int'(Desborde), 1);
        half(5, vc, vp, vq, vb);
        check("ovf_rec_q", vq, 5);
        check("ovf_clr", int'(Desborde), 0);

        // D=1 across reset, then reset mid-measurement
        D = 1'b1;
        do_reset();
        hold(10, vc, dc);
        check("d1_nov", vc, 0);
        check("d1_nodesb", dc, 0);
        half(5, vc, vp, vq, vb);
        half(5, vc, vp, vq, vb);
        half(5, vc, vp, vq, vb);
        check("pre_mid_b", int'(Bloqueado), 1);
        D = ~D;
        step();
        step();
        Reset = 1'b1;
        step();
        check("mid_Q", int'(Q), 0);
        check("mid_V", int'(Valido), 0);
        check("mid_B", int'(Bloqueado), 0);
        check("mid_D", int'(Desborde), 0);
        Reset = 1'b0;
        hold(8, vc, dc);
        check("post_nov", vc, 0);
        half(5, vc, vp, vq, vb);
        check("post_ref_vc", vc, 0);
        half(5, vc, vp, vq, vb);
        check("post_q", vq, 5);
        check("post_b", vb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
